// File: rtl/cla_adder_5bit.sv
// 5-bit carry-lookahead adder, registered operands and registered result (2-edge latency).
// Define CLA_CIN_EN to add a registered carry-in port used as c0.
module cla_adder_5bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] a,
  input  logic [4:0] b,
`ifdef CLA_CIN_EN
  input  logic       cin,
`endif
  output logic [4:0] sum,
  output logic       cout
);

  // No valid/ready: every rising edge launches a new operand pair, and its
  // result is presented on {cout,sum} after the following rising edge.

  logic [4:0] a_r;
  logic [4:0] b_r;
  logic       c0;
  logic [4:0] g;
  logic [4:0] p;
  logic [5:0] c;
  logic [4:0] s;

`ifdef CLA_CIN_EN
  logic cin_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cin_r <= 1'b0;
    end else begin
      cin_r <= cin;
    end
  end

  assign c0 = cin_r;
`else
  assign c0 = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r <= '0;
      b_r <= '0;
    end else begin
      a_r <= a;
      b_r <= b;
    end
  end

  assign g = a_r & b_r;
  assign p = a_r ^ b_r;

  // Each carry is a flat sum-of-products of g/p/c0 so no carry waits on another.
  assign c[0] = c0;
  assign c[1] = g[0]
              | (p[0] & c0);
  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & c0);
  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c0);
  assign c[4] = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c0);
  assign c[5] = g[4]
              | (p[4] & g[3])
              | (p[4] & p[3] & g[2])
              | (p[4] & p[3] & p[2] & g[1])
              | (p[4] & p[3] & p[2] & p[1] & g[0])
              | (p[4] & p[3] & p[2] & p[1] & p[0] & c0);

  assign s = p ^ c[4:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= s;
      cout <= c[5];
    end
  end

endmodule

// File: tb/tb_cla_adder_5bit.sv
// Directed and exhaustive bench for cla_adder_5bit with an expected-result queue.
// Works with or without CLA_CIN_EN defined.
module tb_cla_adder_5bit;

  logic       clk;
  logic       rst;
  logic [4:0] a;
  logic [4:0] b;
  logic       cin;
  logic [4:0] sum;
  logic       cout;

  logic [5:0] exp_q[$];
  string      tag_q[$];
  int         n_vec;
  int         n_err;

  cla_adder_5bit dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
`ifdef CLA_CIN_EN
    .cin  (cin),
`endif
    .sum  (sum),
    .cout (cout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [5:0] model(input logic [4:0] ma, input logic [4:0] mb,
                                       input logic mc);
    logic [5:0] r;
    r = {1'b0, ma} + {1'b0, mb};
`ifdef CLA_CIN_EN
    r = r + {5'b0, mc};
`endif
    return r;
  endfunction

  task automatic check_val(input logic [5:0] exp, input string tag);
    logic [5:0] obs;
    obs = {cout, sum};
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one operand pair, clock it in, then compare the output against the
  // entry queued one edge earlier (its result is now two edges old).
  task automatic step(input logic [4:0] ta, input logic [4:0] tb_v, input logic tc,
                      input string tag);
    logic [5:0] exp;
    string      etag;
    a   = ta;
    b   = tb_v;
    cin = tc;
    exp_q.push_back(model(ta, tb_v, tc));
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    if (exp_q.size() < 2) begin
      n_vec++;
      n_err++;
      $error("FAIL %s: observed queue depth %0d expected 2", tag, exp_q.size());
    end else begin
      exp  = exp_q.pop_front();
      etag = tag_q.pop_front();
      check_val(exp, etag);
    end
  endtask

  task automatic release_reset();
    rst = 1'b1;
    exp_q.delete();
    tag_q.delete();
    // Stage-1 registers hold 0+0 after reset, so the first post-release edge yields 0.
    exp_q.push_back(6'd0);
    tag_q.push_back("post_reset_no_stale");
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    a     = 5'h1F;
    b     = 5'h1F;
    cin   = 1'b1;
    #1;
    check_val(6'd0, "reset_initial");
    repeat (2) begin
      @(posedge clk);
      #1;
      check_val(6'd0, "reset_hold");
    end

    release_reset();
    step(5'd3,  5'd4,  1'b0, "latency_3p4");
    step(5'd0,  5'd0,  1'b0, "after_latency");
    step(5'b11111, 5'b00001, 1'b0, "carry_full_chain");
    step(5'b01111, 5'b00001, 1'b0, "carry_to_msb");
    step(5'd31, 5'd31, 1'b0, "max_31p31");
    step(5'd0,  5'd0,  1'b0, "b2b_0p0");
    step(5'd1,  5'd2,  1'b0, "b2b_1p2");
    step(5'd16, 5'd16, 1'b0, "b2b_16p16");
    step(5'd31, 5'd1,  1'b0, "b2b_31p1");
    step(5'd31, 5'd31, 1'b1, "max_with_cin");
    step(5'd0,  5'd0,  1'b1, "zero_with_cin");
    for (int i = 0; i < 24; i++) begin
      step(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)), "random");
    end
    step(5'd31, 5'd31, 1'b0, "preload_a");
    step(5'd31, 5'd31, 1'b0, "preload_b");
    step(5'd31, 5'd31, 1'b0, "preload_c");

    // Output now holds 62; reset mid-cycle must clear it without a clock edge.
    #3;
    rst = 1'b0;
    a   = 5'h1F;
    b   = 5'h1F;
    cin = 1'b1;
    #1;
    check_val(6'd0, "async_clear_mid_cycle");
    repeat (2) begin
      @(posedge clk);
      #1;
      check_val(6'd0, "reset_hold_mid_op");
    end

    release_reset();
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 32; j++) begin
        step(5'(i), 5'(j), 1'b0, "exhaustive");
      end
    end
    step(5'd0, 5'd0, 1'b0, "flush");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
